// File: rtl/keypad_pkg.sv
// keypad_pkg: shared sizes, scan/classification enums and the frame classifier.
// A frame is ROWS*COLS bits with bit index row*COLS + col, matching the key code.
// The classifier reports NONE, a single KEY with its index, or MULTI (ghosting is left unresolved).
package keypad_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;

    typedef enum logic {
        SCAN,
        EVAL
    } scan_state_e;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } key_class_e;

    // idx is only meaningful for KEY; it is forced to zero otherwise so that
    // whole-struct compares treat every NONE (or every MULTI) as equal.
    typedef struct packed {
        key_class_e          cls;
        logic [CODE_W-1:0]   idx;
    } key_state_t;

    function automatic key_state_t classify_frame(input logic [ROWS*COLS-1:0] frame);
        key_state_t  res;
        int unsigned ones;
        ones    = 0;
        res.cls = NONE;
        res.idx = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (frame[i]) begin
                ones++;
                res.idx = CODE_W'(i);
            end
        end
        if (ones == 1) begin
            res.cls = KEY;
        end else if (ones > 1) begin
            res.cls = MULTI;
        end
        if (res.cls != KEY) begin
            res.idx = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key event bus between the scanner (master) and its consumer (slave).
// Transfer happens on a clock edge with key_valid && key_ready; key_code is stable while pending.
// key_held and overflow are status lines that ride alongside the handshake.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              key_held;
    logic              overflow;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overflow,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overflow,
        output key_ready
    );

endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce; accepts a new key state after DEBOUNCE identical frames.
// Latency: acc_chg is combinational in the EVAL cycle; acc_state updates on the edge that ends it.
// Backpressure: none; one decision per frame strobe, downstream must absorb or drop the change.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_vld,
    input  key_state_t frame_cls,
    output key_state_t acc_state,
    output logic       acc_chg
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE);
    localparam key_state_t ST_NONE = '{cls: NONE, idx: '0};

    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
        $error("DEBOUNCE must be in 1..15");
    end

    logic [3:0] cnt_q, cnt_d;
    key_state_t prev_q, prev_d;
    key_state_t acc_q, acc_d;

    // Count consecutive identical frames and promote a stable, different class to accepted.
    always_comb begin
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        acc_chg = 1'b0;
        if (frame_vld) begin
            prev_d = frame_cls;
            if (frame_cls == prev_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = 4'd1;
            end
            if (cnt_d == CNT_MAX && frame_cls != acc_q) begin
                acc_d   = frame_cls;
                acc_chg = 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            prev_q <= ST_NONE;
            acc_q  <= ST_NONE;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_state = acc_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scans a 4x4 keypad, debounces whole frames, emits key codes on a valid/ready bus.
// Latency: key_valid rises one clock after the EVAL cycle of the DEBOUNCE-th stable frame.
// Backpressure: an event arriving while an unaccepted one is pending is dropped and overflow pulses.
// Optional: define KEYPAD_SCAN_REPEAT_EN to compile in auto-repeat while a single key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV     = 1000,
    parameter int DEBOUNCE    = 4,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROWS-1:0]  row_drv,
    input  logic [COLS-1:0]  col_in,
    keypad_scanner_if.master kbus
);

    localparam int DW_W  = $clog2(CLK_DIV);
    localparam int ROW_W = $clog2(ROWS);
    localparam int FRM_W = ROWS * COLS;

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("CLK_DIV must be at least 4 to cover settle plus synchronizer");
    end

    scan_state_e        state_q, state_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic [COLS-1:0]    col_meta_q, col_sync_q;

    logic               frame_vld;
    key_state_t         frame_cls;
    key_state_t         acc_state;
    logic               acc_chg;
    logic               rep_fire;

    logic               ev_vld;
    logic [CODE_W-1:0]  ev_code;
    logic [CODE_W-1:0]  key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               overflow_q, overflow_d;

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= '0;
            col_sync_q <= '0;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    // Scan sequencer: dwell on each row, capture its columns on the last dwell cycle, then EVAL.
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        row_d     = row_q;
        frame_d   = frame_q;
        frame_vld = 1'b0;
        case (state_q)
            SCAN: begin
                if (dwell_q == DW_W'(CLK_DIV - 1)) begin
                    dwell_d                     = '0;
                    frame_d[row_q*COLS +: COLS] = col_sync_q;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        state_d = EVAL;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            EVAL: begin
                // Row 3 stays driven for this cycle; the frame is complete in frame_q.
                frame_vld = 1'b1;
                row_d     = '0;
                state_d   = SCAN;
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Scan state registers; reset aborts any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            dwell_q <= '0;
            row_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    assign row_drv   = ROWS'(1) << row_q;
    assign frame_cls = classify_frame(frame_q);

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame_vld (frame_vld),
        .frame_cls (frame_cls),
        .acc_state (acc_state),
        .acc_chg   (acc_chg)
    );

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("REPEAT_DLY and REPEAT_RATE must be at least 1");
    end

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic [REP_W-1:0] rep_next;

    // Frame counter while a key is accepted: first period is the delay, then the repeat rate.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        rep_next    = rep_cnt_q + REP_W'(1);
        if (frame_vld) begin
            if (acc_chg) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else if (acc_state.cls == KEY) begin
                if (rep_next == (rep_first_q ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_RATE))) begin
                    rep_fire    = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_next;
                end
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    if (REPEAT_DLY < 0 || REPEAT_RATE < 0) begin : g_bad_repeat
        $error("REPEAT_DLY and REPEAT_RATE must be non-negative");
    end

    assign rep_fire = 1'b0;
`endif

    // Merge press and repeat events; an accepted-state change restarts the repeat timer so they never coincide.
    always_comb begin
        ev_vld  = 1'b0;
        ev_code = '0;
        if (acc_chg && frame_cls.cls == KEY) begin
            ev_vld  = 1'b1;
            ev_code = frame_cls.idx;
        end else if (rep_fire) begin
            ev_vld  = 1'b1;
            ev_code = acc_state.idx;
        end
    end

    // Output register: load when empty or draining this cycle, otherwise drop and flag overflow.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overflow_d  = 1'b0;
        if (ev_vld) begin
            if (!key_valid_q || kbus.key_ready) begin
                key_code_d  = ev_code;
                key_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (key_valid_q && kbus.key_ready) begin
            key_valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign kbus.key_code  = key_code_q;
    assign kbus.key_valid = key_valid_q;
    assign kbus.overflow  = overflow_q;
    assign kbus.key_held  = (acc_state.cls == KEY);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized key patterns against a frame-level reference model.
// Latency: the model tracks the frame schedule from reset release and predicts every output each cycle.
// Backpressure: key_ready is driven low, high or random per cycle to exercise drops and overflow.
module tb_keypad_scanner;

    localparam int CLK_DIV     = 4;
    localparam int DEBOUNCE    = 2;
    localparam int REPEAT_DLY  = 3;
    localparam int REPEAT_RATE = 2;
    localparam int FRAME       = 4 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_drv;
    logic [3:0]  col_in;
    logic [15:0] pressed;

    keypad_scanner_if kif();

    keypad_scanner #(
        .CLK_DIV     (CLK_DIV),
        .DEBOUNCE    (DEBOUNCE),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_drv (row_drv),
        .col_in  (col_in),
        .kbus    (kif)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its row drive to its column line.
    always_comb begin
        col_in = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row_drv[r] && pressed[r*4+c]) col_in[c] = 1'b1;
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int xfers  = 0;
    int ovfs   = 0;

    // Reference model state. Key classes: -1 none, -2 multi, 0..15 single key index.
    int fk;
    int m_prev, m_cnt, m_acc, rep_n, rep_lim;
    bit exp_valid, exp_held, exp_ovf;
    int exp_code;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    endtask

    function automatic int classify(input logic [15:0] p);
        if (p == 16'h0) return -1;
        if ($countones(p) > 1) return -2;
        for (int i = 0; i < 16; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] rand_pat(input logic [15:0] prev);
        int          sel;
        logic [15:0] p;
        sel = $urandom_range(0, 9);
        if (sel < 5)      p = prev;
        else if (sel < 7) p = 16'h0;
        else if (sel < 9) p = 16'h1 << $urandom_range(0, 15);
        else              p = (16'h1 << $urandom_range(0, 7)) | (16'h1 << $urandom_range(8, 15));
        return p;
    endfunction

    task automatic model_reset();
        m_prev    = -1;
        m_cnt     = 0;
        m_acc     = -1;
        rep_n     = 0;
        rep_lim   = REPEAT_DLY;
        exp_valid = 1'b0;
        exp_held  = 1'b0;
        exp_ovf   = 1'b0;
        exp_code  = 0;
        fk        = 0;
    endtask

    // One clock: drive ready, check all outputs, advance the model across the closing edge.
    task automatic step(input bit rdy);
        int cls;
        bit evt;
        int ecode;
        kif.key_ready = rdy;
        chk("row_drv", row_drv, (fk < 4 * CLK_DIV) ? (1 << (fk / CLK_DIV)) : 8);
        chk("key_valid", kif.key_valid, exp_valid);
        chk("key_code", kif.key_code, exp_code);
        chk("key_held", kif.key_held, exp_held);
        chk("overflow", kif.overflow, exp_ovf);
        if (kif.key_valid && rdy) xfers++;
        if (kif.overflow) ovfs++;
        evt   = 1'b0;
        ecode = 0;
        if (fk == FRAME - 1) begin
            cls = classify(pressed);
            if (cls == m_prev) begin
                if (m_cnt < DEBOUNCE) m_cnt++;
            end else begin
                m_cnt = 1;
            end
            m_prev = cls;
            if (m_cnt == DEBOUNCE && cls != m_acc) begin
                m_acc   = cls;
                rep_n   = 0;
                rep_lim = REPEAT_DLY;
                if (cls >= 0) begin
                    evt   = 1'b1;
                    ecode = cls;
                end
            end
`ifdef KEYPAD_SCAN_REPEAT_EN
            else if (m_acc >= 0) begin
                rep_n++;
                if (rep_n == rep_lim) begin
                    evt     = 1'b1;
                    ecode   = m_acc;
                    rep_n   = 0;
                    rep_lim = REPEAT_RATE;
                end
            end
`endif
        end
        exp_ovf = 1'b0;
        if (evt) begin
            if (!exp_valid || rdy) begin
                exp_valid = 1'b1;
                exp_code  = ecode;
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        exp_held = (m_acc >= 0);
        @(posedge clk);
        #1;
        fk = (fk == FRAME - 1) ? 0 : fk + 1;
    endtask

    // mode: 0 ready low, 1 ready high, 2 ready random per cycle.
    task automatic run_frame(input logic [15:0] pat, input int mode, input int ncyc);
        pressed = pat;
        for (int i = 0; i < ncyc; i++) begin
            step(mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : ($urandom_range(0, 99) < 60));
        end
    endtask

    task automatic run_frames(input logic [15:0] pat, input int mode, input int n);
        for (int i = 0; i < n; i++) run_frame(pat, mode, FRAME);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_row_drv", row_drv, 1);
        chk("rst_key_valid", kif.key_valid, 0);
        chk("rst_key_code", kif.key_code, 0);
        chk("rst_key_held", kif.key_held, 0);
        chk("rst_overflow", kif.overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int          base;
        logic [15:0] pat;
        pressed       = 16'h0;
        kif.key_ready = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Idle scanning: row rotation and no events.
        base = xfers;
        run_frames(16'h0, 1, 3);
        chk("idle_xfers", xfers - base, 0);

        // Stable press of row 2 col 1 (code 9), then release.
        base = xfers;
        run_frames(16'h0200, 1, 4);
        chk("press9_held", kif.key_held, 1);
        run_frames(16'h0, 1, 3);
        chk("press9_xfers", xfers - base, 1);
        chk("press9_released", kif.key_held, 0);

        // One-frame glitch is ignored; the following stable press yields one event.
        base = xfers;
        run_frame(16'h0200, 1, FRAME);
        run_frames(16'h0, 1, 2);
        chk("glitch_xfers", xfers - base, 0);
        run_frames(16'h0200, 1, 3);
        run_frames(16'h0, 1, 3);
        chk("bounce_xfers", xfers - base, 1);

        // Two keys on rows 0 and 3: MULTI, no event, not held.
        base = xfers;
        run_frames(16'h1001, 1, 4);
        chk("multi_held", kif.key_held, 0);
        run_frames(16'h0, 1, 3);
        chk("multi_xfers", xfers - base, 0);

        // Consumer stalled: code 5 is kept, the later code 6 press is dropped with one overflow.
        base = ovfs;
        run_frames(16'h0020, 0, 3);
        run_frames(16'h0, 0, 3);
        run_frames(16'h0040, 0, 3);
        chk("stall_code", kif.key_code, 5);
        chk("stall_valid", kif.key_valid, 1);
        run_frames(16'h0, 1, 3);
        chk("stall_ovf", ovfs - base, 1);
        chk("drained_valid", kif.key_valid, 0);

        // Reset in mid-frame discards the partial frame and the debounce history.
        run_frame(16'h0008, 1, FRAME);
        run_frame(16'h0008, 1, 9);
        do_reset();
        base = xfers;
        run_frame(16'h0008, 1, FRAME);
        chk("rst_abort_xfers", xfers - base, 0);
        run_frame(16'h0008, 1, FRAME);
        run_frames(16'h0, 1, 3);
        chk("rst_press_xfers", xfers - base, 1);

`ifdef KEYPAD_SCAN_REPEAT_EN
        // Held key 0: events at acceptance, +3, +5 and +7 frames.
        base = xfers;
        run_frames(16'h0001, 1, 9);
        run_frames(16'h0, 1, 3);
        chk("repeat_xfers", xfers - base, 4);
`endif

        // Randomized patterns and backpressure against the model.
        pat = 16'h0;
        for (int f = 0; f < 150; f++) begin
            pat = rand_pat(pat);
            run_frame(pat, ($urandom_range(0, 3) == 0) ? 0 : 2, FRAME);
        end
        run_frames(16'h0, 1, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Sequential scan controller for the 4x4 matrix keypad. Drives one row at a time, samples the four column lines, debounces whole scan frames, and delivers each accepted key press as a 4-bit code over a valid/ready handshake. Sits between the keypad pins and whatever consumes key events, replacing direct combinational decoding of the row/column lines.

## Interface
- CLK_DIV, 1000: clocks per row dwell; legal minimum 4.
- DEBOUNCE, 4: consecutive identical frames required to accept a new key state; legal range 1..15.
- REPEAT_DLY, 50: frames from acceptance to first auto-repeat; used only when auto-repeat is compiled in.
- REPEAT_RATE, 10: frames between subsequent repeats; used only when auto-repeat is compiled in.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- row_drv  out  4  one-hot active-high row drive.
- col_in  in  4  active-high column sense; asynchronous to clk.
- key_code  out  4  accepted key index, row*4 + col (0..15).
- key_valid  out  1  event pending in the output register.
- key_ready  in  1  consumer accepts the event when high with key_valid.
- key_held  out  1  high while an accepted single key remains pressed.
- overflow  out  1  one-cycle pulse when an event is dropped.

## Operation
- Reset values: row_drv=4'b0001, key_code=0, key_valid=0, key_held=0, overflow=0; dwell/row/debounce/repeat counters 0; accepted state NONE.
- col_in passes through a two-flop synchronizer before use.
- States: SCAN (dwell on current row), EVAL (one cycle after row 3 dwell), back to SCAN with row 0.
- SCAN: the dwell counter counts 0..CLK_DIV-1. The synchronized columns are captured into the frame register slot for the current row on the last dwell cycle. row_drv then rotates left (row 3 -> row 0 via EVAL).
- EVAL classifies the 16-bit frame:
  - all zero: NONE.
  - exactly one bit set: KEY(index).
  - two or more bits set: MULTI, treated as NONE for events; ghosting is not resolved.
- Debounce: if the classification equals the previous frame's, the counter increments, saturating at DEBOUNCE; otherwise it resets to 1.
- When the counter reaches DEBOUNCE and the classification differs from the accepted state, the accepted state is updated.
  - A transition into KEY(k) generates a press event with code k and sets key_held.
  - A transition to NONE/MULTI clears key_held and generates no event.
  - A direct KEY(a) -> KEY(b) transition generates a press event for b.
- Event delivery:
  - If key_valid is 0, or key_valid&&key_ready in the same cycle, the event loads key_code and key_valid=1.
  - Otherwise the event is dropped, key_code is unchanged, and overflow pulses.
  - key_valid clears on key_valid&&key_ready when no new event loads.
- Reset asserted mid-frame aborts the scan immediately; the partial frame is discarded.

## Timing
- Frame length: 4*CLK_DIV + 1 clocks (EVAL costs one cycle, with row_drv held at row 3).
- Column sample latency: 2 clocks of synchronizer; dwell must cover settle plus sync, hence CLK_DIV >= 4.
- Press latency: key_valid rises 1 clock after the EVAL of the DEBOUNCE-th stable frame.
- key_held changes in the same cycle as the accepted-state update.
- Handshake transfer occurs on a rising clk edge with key_valid&&key_ready. key_code is stable while key_valid is high and not accepted.

## Configuration
- KEYPAD_SCAN_REPEAT_EN defined: while the accepted state is KEY(k), a frame counter runs.
  - A repeat event with code k is generated REPEAT_DLY frames after acceptance, then every REPEAT_RATE frames.
  - Repeat events follow the same delivery and overflow rules as press events.
  - Leaving KEY(k) clears the counter.
- Not defined: repeat logic is absent, REPEAT_* are ignored, and exactly one event is produced per accepted press.

## Structure
- Shared package keypad_pkg holds:
  - ROWS/COLS=4 and CODE_W=4;
  - the scan state enum (SCAN, EVAL);
  - the classification enum (NONE, KEY, MULTI);
  - a function encoding a 16-bit frame into class plus index.
- One natural sub-module: keypad_debounce. It takes the frame class/index, does the compare and count, and outputs the accepted state plus a change strobe.
- Synchronizer, scan sequencer and output register stay in keypad_scanner.

## Test plan
Bench parameters: CLK_DIV=4, DEBOUNCE=2, with key_ready held high unless stated.
- Reset released, no key: row_drv cycles 0001->0010->0100->1000 every 4 clocks, with 1 extra clock at 1000. key_valid stays 0.
- Hold key row 2, col 1: key_code=9 and key_valid=1 for one cycle after the 2nd stable frame EVAL. key_held=1 until release is debounced.
- Bounce col 1 on row 2 with a 1-frame glitch: no event. A stable press then produces exactly one code 9.
- Press rows 0 and 3 simultaneously (MULTI): no event and key_held=0.
- key_ready=0, press code 5, release, then press code 6: key_code stays 5 with key_valid=1, and overflow pulses once. Raising key_ready clears key_valid.
- With KEYPAD_SCAN_REPEAT_EN, REPEAT_DLY=3, REPEAT_RATE=2, holding key 0: events at acceptance, +3 frames, +5 frames, +7 frames.
